// File: rtl/prc_pfs_rcv.sv
// prc_pfs_rcv: PRC receiver for PFS packet fetch requests.
// Requests are buffered in a credit-managed FIFO. Each request is split into
// per-segment read commands toward packet memory. One credit is returned per
// fully segmented request and per zero-length request.
// Optional performance counters: define PRC_PFS_RCV_PERF_EN.
module prc_pfs_rcv #(
  parameter int DEPTH    = 8,
  parameter int PTR_W    = 20,
  parameter int LEN_W    = 14,
  parameter int PORT_W   = 5,
  parameter int SEG_LOG2 = 8
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                pfs_req_valid,
  input  logic [PTR_W-1:0]    pfs_req_ptr,
  input  logic [LEN_W-1:0]    pfs_req_len,
  input  logic [PORT_W-1:0]   pfs_req_port,
  output logic                prc_credit_ret,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [PTR_W-1:0]    rd_ptr,
  output logic [PORT_W-1:0]   rd_port,
  output logic [SEG_LOG2:0]   rd_bytes,
  output logic                rd_sop,
  output logic                rd_eop,
  output logic                err_ovf,
  output logic                err_len0,
  output logic [31:0]         perf_req_cnt,
  output logic [31:0]         perf_seg_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int PW  = CW + 1;
  localparam int SEG = 1 << SEG_LOG2;
  localparam int BW  = SEG_LOG2 + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [PTR_W-1:0]  mem_ptr  [DEPTH];
  logic [LEN_W-1:0]  mem_len  [DEPTH];
  logic [PORT_W-1:0] mem_port [DEPTH];

  logic [AW-1:0]    head, tail, head_nxt, ld_idx;
  logic [CW-1:0]    count;
  logic [PW-1:0]    credit_pend, credit_sum;
  logic [LEN_W-1:0] remaining, rem_nxt;
  state_t           state;

  logic full, push_ok, ovf_drop, len0_drop, hs, pop, has_next;

  // Bytes carried by a segment given the bytes still to be read.
  function automatic logic [BW-1:0] seg_bytes(input logic [LEN_W-1:0] rem);
    return (rem >= LEN_W'(SEG)) ? BW'(SEG) : BW'(rem);
  endfunction

  // True when the remaining bytes fit in one segment.
  function automatic logic seg_last(input logic [LEN_W-1:0] rem);
    return rem <= LEN_W'(SEG);
  endfunction

  // Full is judged on the pre-pop count, so a pop never frees room for a
  // push in the same cycle.
  assign full      = (count == CW'(DEPTH));
  assign ovf_drop  = pfs_req_valid && full;
  assign len0_drop = pfs_req_valid && !full && (pfs_req_len == '0);
  assign push_ok   = pfs_req_valid && !full && (pfs_req_len != '0);
  assign hs        = rd_valid && rd_ready;
  assign pop       = hs && rd_eop;
  assign has_next  = (count > CW'(1));
  assign head_nxt  = head + AW'(1);
  assign ld_idx    = (state == ACTIVE) ? head_nxt : head;
  assign rem_nxt   = remaining - LEN_W'(SEG);
  assign credit_sum = credit_pend + PW'(pop) + PW'(len0_drop);

  // FIFO payload storage; data only, not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_ptr[tail]  <= pfs_req_ptr;
      mem_len[tail]  <= pfs_req_len;
      mem_port[tail] <= pfs_req_port;
    end
  end

  // FIFO pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      err_ovf  <= 1'b0;
      err_len0 <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + AW'(1);
      if (pop)     head <= head_nxt;
      count <= count + CW'(push_ok) - CW'(pop);
      if (ovf_drop)  err_ovf  <= 1'b1;
      if (len0_drop) err_len0 <= 1'b1;
    end
  end

  // Credit return; a pop and a len0 drop in the same cycle queue a second
  // pulse so every credit goes back as its own one-cycle pulse.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      prc_credit_ret <= 1'b0;
      credit_pend    <= '0;
    end else begin
      prc_credit_ret <= (credit_sum != '0);
      credit_pend    <= credit_sum - PW'(credit_sum != '0);
    end
  end

  // Segmentation FSM with registered command outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      rd_valid  <= 1'b0;
      rd_ptr    <= '0;
      rd_port   <= '0;
      rd_bytes  <= '0;
      rd_sop    <= 1'b0;
      rd_eop    <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            rd_ptr    <= mem_ptr[ld_idx];
            rd_port   <= mem_port[ld_idx];
            remaining <= mem_len[ld_idx];
            rd_bytes  <= seg_bytes(mem_len[ld_idx]);
            rd_eop    <= seg_last(mem_len[ld_idx]);
            rd_sop    <= 1'b1;
            rd_valid  <= 1'b1;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (hs) begin
            if (!rd_eop) begin
              rd_ptr    <= rd_ptr + PTR_W'(1);
              remaining <= rem_nxt;
              rd_bytes  <= seg_bytes(rem_nxt);
              rd_eop    <= seg_last(rem_nxt);
              rd_sop    <= 1'b0;
            end else if (has_next) begin
              rd_ptr    <= mem_ptr[ld_idx];
              rd_port   <= mem_port[ld_idx];
              remaining <= mem_len[ld_idx];
              rd_bytes  <= seg_bytes(mem_len[ld_idx]);
              rd_eop    <= seg_last(mem_len[ld_idx]);
              rd_sop    <= 1'b1;
            end else begin
              rd_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PRC_PFS_RCV_PERF_EN
  // Saturating increment for the 32-bit performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // Accepted-request and issued-segment counters.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      perf_req_cnt <= '0;
      perf_seg_cnt <= '0;
    end else begin
      perf_req_cnt <= sat_inc(perf_req_cnt, push_ok);
      perf_seg_cnt <= sat_inc(perf_seg_cnt, hs);
    end
  end
`else
  assign perf_req_cnt = '0;
  assign perf_seg_cnt = '0;
`endif

endmodule

// File: tb/tb_prc_pfs_rcv.sv
// Directed testbench for prc_pfs_rcv (default parameters).
module tb_prc_pfs_rcv;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        pfs_req_valid = 1'b0;
  logic [19:0] pfs_req_ptr = '0;
  logic [13:0] pfs_req_len = '0;
  logic [4:0]  pfs_req_port = '0;
  logic        prc_credit_ret;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [19:0] rd_ptr;
  logic [4:0]  rd_port;
  logic [8:0]  rd_bytes;
  logic        rd_sop, rd_eop;
  logic        err_ovf, err_len0;
  logic [31:0] perf_req_cnt, perf_seg_cnt;

  int vecs = 0;
  int errs = 0;
  int credit_total = 0;

  logic [31:0] obs;
  assign obs = {rd_valid, rd_ptr, rd_bytes, rd_sop, rd_eop};

  prc_pfs_rcv dut (
    .clk(clk), .arst(arst),
    .pfs_req_valid(pfs_req_valid), .pfs_req_ptr(pfs_req_ptr),
    .pfs_req_len(pfs_req_len), .pfs_req_port(pfs_req_port),
    .prc_credit_ret(prc_credit_ret),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ptr(rd_ptr),
    .rd_port(rd_port), .rd_bytes(rd_bytes), .rd_sop(rd_sop), .rd_eop(rd_eop),
    .err_ovf(err_ovf), .err_len0(err_len0),
    .perf_req_cnt(perf_req_cnt), .perf_seg_cnt(perf_seg_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (prc_credit_ret === 1'b1) credit_total++;

  function automatic logic [31:0] cmd(input logic v, input logic [19:0] p,
                                      input int b, input logic s, input logic e);
    return {v, p, 9'(b), s, e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [19:0] p, input int len, input logic [4:0] port);
    pfs_req_valid = 1'b1;
    pfs_req_ptr   = p;
    pfs_req_len   = 14'(len);
    pfs_req_port  = port;
  endtask

  task automatic test_reset();
    #1;
    vecs++;
    if ({obs, rd_port, prc_credit_ret, err_ovf, err_len0} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got %h/%h/%b%b%b need 0", obs, rd_port,
               prc_credit_ret, err_ovf, err_len0);
    end
    vecs++;
    if ({perf_req_cnt, perf_seg_cnt} !== 64'd0) begin
      errs++;
      $display("FAIL reset_perf got %h %h need 0", perf_req_cnt, perf_seg_cnt);
    end
    tick(); tick();
    arst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int c0;
    c0 = credit_total;
    rd_ready = 1'b1;
    drive_req(20'h00100, 600, 5'd3);
    tick();
    pfs_req_valid = 1'b0;
    vecs++;
    if (rd_valid !== 1'b0) begin
      errs++; $display("FAIL single_latency_n1 rd_valid got %b need 0", rd_valid);
    end
    tick();
    vecs++;
    if (obs !== cmd(1, 20'h00100, 256, 1, 0) || rd_port !== 5'd3) begin
      errs++; $display("FAIL single_seg0 got %h port %0d need %h port 3", obs, rd_port, cmd(1, 20'h00100, 256, 1, 0));
    end
    tick();
    vecs++;
    if (obs !== cmd(1, 20'h00101, 256, 0, 0)) begin
      errs++; $display("FAIL single_seg1 got %h need %h", obs, cmd(1, 20'h00101, 256, 0, 0));
    end
    tick();
    vecs++;
    if (obs !== cmd(1, 20'h00102, 88, 0, 1)) begin
      errs++; $display("FAIL single_seg2 got %h need %h", obs, cmd(1, 20'h00102, 88, 0, 1));
    end
    tick();
    vecs++;
    if (rd_valid !== 1'b0 || prc_credit_ret !== 1'b1) begin
      errs++; $display("FAIL single_done valid %b credit %b need 0 1", rd_valid, prc_credit_ret);
    end
    tick(); tick();
    vecs++;
    if (credit_total - c0 !== 1) begin
      errs++; $display("FAIL single_credits got %0d need 1", credit_total - c0);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = credit_total;
    rd_ready = 1'b1;
    drive_req(20'h00200, 256, 5'd1);
    tick();
    drive_req(20'h00300, 1, 5'd2);
    tick();
    pfs_req_valid = 1'b0;
    vecs++;
    if (obs !== cmd(1, 20'h00200, 256, 1, 1) || rd_port !== 5'd1) begin
      errs++; $display("FAIL b2b_first got %h port %0d need %h port 1", obs, rd_port, cmd(1, 20'h00200, 256, 1, 1));
    end
    tick();
    vecs++;
    if (obs !== cmd(1, 20'h00300, 1, 1, 1) || rd_port !== 5'd2 || prc_credit_ret !== 1'b1) begin
      errs++; $display("FAIL b2b_second got %h port %0d credit %b need %h port 2 credit 1", obs, rd_port, prc_credit_ret, cmd(1, 20'h00300, 1, 1, 1));
    end
    tick();
    vecs++;
    if (rd_valid !== 1'b0 || prc_credit_ret !== 1'b1) begin
      errs++; $display("FAIL b2b_done valid %b credit %b need 0 1", rd_valid, prc_credit_ret);
    end
    tick(); tick();
    vecs++;
    if (credit_total - c0 !== 2) begin
      errs++; $display("FAIL b2b_credits got %0d need 2", credit_total - c0);
    end
  endtask

  task automatic test_overflow();
    int c0;
    c0 = credit_total;
    rd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_req(20'(32'h700 + i), 1, 5'd0);
      tick();
    end
    pfs_req_valid = 1'b0;
    vecs++;
    if (err_ovf !== 1'b1) begin
      errs++; $display("FAIL ovf_flag got %b need 1", err_ovf);
    end
    tick();
    vecs++;
    if (credit_total - c0 !== 0) begin
      errs++; $display("FAIL ovf_no_credit got %0d need 0", credit_total - c0);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (obs !== cmd(1, 20'(32'h700 + i), 1, 1, 1)) begin
        errs++; $display("FAIL ovf_drain%0d got %h need %h", i, obs, cmd(1, 20'(32'h700 + i), 1, 1, 1));
      end
      tick();
    end
    vecs++;
    if (rd_valid !== 1'b0) begin
      errs++; $display("FAIL ovf_ninth_dropped rd_valid got %b need 0", rd_valid);
    end
    tick(); tick();
    vecs++;
    if (credit_total - c0 !== 8) begin
      errs++; $display("FAIL ovf_credits got %0d need 8", credit_total - c0);
    end
  endtask

  task automatic test_stall();
    int c0;
    c0 = credit_total;
    rd_ready = 1'b1;
    drive_req(20'h00400, 1000, 5'd7);
    tick();
    pfs_req_valid = 1'b0;
    tick();
    vecs++;
    if (obs !== cmd(1, 20'h00400, 256, 1, 0)) begin
      errs++; $display("FAIL stall_seg0 got %h need %h", obs, cmd(1, 20'h00400, 256, 1, 0));
    end
    tick();
    rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (obs !== cmd(1, 20'h00401, 256, 0, 0) || rd_port !== 5'd7) begin
        errs++; $display("FAIL stall_hold%0d got %h port %0d need %h port 7", k, obs, rd_port, cmd(1, 20'h00401, 256, 0, 0));
      end
      if (k < 2) tick();
    end
    rd_ready = 1'b1;
    tick();
    vecs++;
    if (obs !== cmd(1, 20'h00402, 256, 0, 0)) begin
      errs++; $display("FAIL stall_seg2 got %h need %h", obs, cmd(1, 20'h00402, 256, 0, 0));
    end
    tick();
    vecs++;
    if (obs !== cmd(1, 20'h00403, 232, 0, 1)) begin
      errs++; $display("FAIL stall_seg3 got %h need %h", obs, cmd(1, 20'h00403, 232, 0, 1));
    end
    tick(); tick(); tick();
    vecs++;
    if (rd_valid !== 1'b0 || credit_total - c0 !== 1) begin
      errs++; $display("FAIL stall_done valid %b credits %0d need 0 1", rd_valid, credit_total - c0);
    end
  endtask

  task automatic test_wrap_len0();
    int c0;
    rd_ready = 1'b1;
    drive_req(20'hFFFFF, 512, 5'd4);
    tick();
    pfs_req_valid = 1'b0;
    tick();
    vecs++;
    if (obs !== cmd(1, 20'hFFFFF, 256, 1, 0)) begin
      errs++; $display("FAIL wrap_seg0 got %h need %h", obs, cmd(1, 20'hFFFFF, 256, 1, 0));
    end
    tick();
    vecs++;
    if (obs !== cmd(1, 20'h00000, 256, 0, 1)) begin
      errs++; $display("FAIL wrap_seg1 got %h need %h", obs, cmd(1, 20'h00000, 256, 0, 1));
    end
    tick(); tick(); tick();
    c0 = credit_total;
    vecs++;
    if (err_len0 !== 1'b0) begin
      errs++; $display("FAIL len0_before got %b need 0", err_len0);
    end
    drive_req(20'h00055, 0, 5'd1);
    tick();
    pfs_req_valid = 1'b0;
    vecs++;
    if (err_len0 !== 1'b1 || prc_credit_ret !== 1'b1 || rd_valid !== 1'b0) begin
      errs++; $display("FAIL len0_drop err %b credit %b valid %b need 1 1 0", err_len0, prc_credit_ret, rd_valid);
    end
    tick();
    vecs++;
    if (rd_valid !== 1'b0 || prc_credit_ret !== 1'b0) begin
      errs++; $display("FAIL len0_after valid %b credit %b need 0 0", rd_valid, prc_credit_ret);
    end
    tick();
    vecs++;
    if (credit_total - c0 !== 1) begin
      errs++; $display("FAIL len0_credits got %0d need 1", credit_total - c0);
    end
  endtask

  task automatic test_mid_reset();
    int c0;
    c0 = credit_total;
    rd_ready = 1'b1;
    drive_req(20'h00500, 700, 5'd6);
    tick();
    pfs_req_valid = 1'b0;
    tick();
    tick();
    vecs++;
    if (obs !== cmd(1, 20'h00501, 256, 0, 0)) begin
      errs++; $display("FAIL rst_seg1 got %h need %h", obs, cmd(1, 20'h00501, 256, 0, 0));
    end
    arst = 1'b1;
    #1;
    vecs++;
    if ({obs, rd_port, prc_credit_ret, err_ovf, err_len0} !== '0) begin
      errs++; $display("FAIL rst_async got %h/%h/%b%b%b need 0", obs, rd_port, prc_credit_ret, err_ovf, err_len0);
    end
    tick();
    arst = 1'b0;
    tick(); tick(); tick();
    vecs++;
    if (rd_valid !== 1'b0 || credit_total - c0 !== 0) begin
      errs++; $display("FAIL rst_flushed valid %b credits %0d need 0 0", rd_valid, credit_total - c0);
    end
    drive_req(20'h00600, 10, 5'd9);
    tick();
    pfs_req_valid = 1'b0;
    tick();
    vecs++;
    if (obs !== cmd(1, 20'h00600, 10, 1, 1) || rd_port !== 5'd9) begin
      errs++; $display("FAIL rst_new_req got %h port %0d need %h port 9", obs, rd_port, cmd(1, 20'h00600, 10, 1, 1));
    end
    tick(); tick(); tick();
    vecs++;
    if (credit_total - c0 !== 1) begin
      errs++; $display("FAIL rst_credits got %0d need 1", credit_total - c0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_wrap_len0();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/prc_pfs_rcv.md
Name: prc_pfs_rcv

Overview:
- Receiving end of the PFS-to-PRC packet fetch request path, inside the PRC.
- Accepts packet fetch requests (segment pointer, byte length, egress port) issued by the Packet Fetch Scheduler and buffers them in a credit-managed FIFO.
- Splits each request into per-segment read commands toward packet memory under a valid/ready handshake.
- Returns one credit to the PFS per fully segmented request.

Parameters:
- DEPTH, 8, request FIFO entries; also the PFS initial credit count. Power of 2, 2..32.
- PTR_W, 20, segment pointer width.
- LEN_W, 14, packet byte-length width.
- PORT_W, 5, egress port id width.
- SEG_LOG2, 8, log2 of segment size in bytes (256 B).

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- pfs_req_valid  in  1  request strobe; one request per cycle. No backpressure; credit-governed.
- pfs_req_ptr  in  PTR_W  first segment pointer.
- pfs_req_len  in  LEN_W  packet length in bytes. 0 is illegal.
- pfs_req_port  in  PORT_W  egress port.
- prc_credit_ret  out  1  one-cycle pulse; returns one request credit to PFS.
- rd_valid  out  1  segment read command valid.
- rd_ready  in  1  memory read path accepts command.
- rd_ptr  out  PTR_W  segment pointer.
- rd_port  out  PORT_W  egress port.
- rd_bytes  out  SEG_LOG2+1  valid bytes in segment, 1..2^SEG_LOG2.
- rd_sop  out  1  first segment of packet.
- rd_eop  out  1  last segment of packet.
- err_ovf  out  1  sticky: request arrived with FIFO full.
- err_len0  out  1  sticky: zero-length request received.
- perf_req_cnt  out  32  requests accepted (optional feature).
- perf_seg_cnt  out  32  segments issued (optional feature).

Behaviour:
- Reset (arst high, async): FIFO empty, FSM in IDLE. All outputs 0: rd_valid, rd_* fields, prc_credit_ret, err_*, perf_*. Mid-operation reset discards in-flight requests and the partial packet; no credit is returned for them. The PFS resets its credit counter to DEPTH in the same domain.
- Push:
  - pfs_req_valid with count<DEPTH writes {ptr,len,port} at the clock edge.
  - Full is evaluated before any same-cycle pop. A push with count==DEPTH is dropped and sets err_ovf, even if a pop happens that cycle.
  - len==0 is dropped (not written), sets err_len0, and pulses prc_credit_ret in the next cycle.
- Registered command outputs; FSM states IDLE and ACTIVE.
  - IDLE: if the FIFO is non-empty, load the head into the output registers: rd_ptr=ptr, rd_port=port, rd_sop=1, remaining=len, rd_bytes=min(len,256), rd_eop=(len<=256). Set rd_valid=1 and go to ACTIVE.
  - ACTIVE, rd_valid && rd_ready, not eop: rd_ptr+=1 (wraps modulo 2^PTR_W), remaining-=256, rd_sop=0. Recompute rd_bytes and rd_eop from the new remaining.
  - ACTIVE, rd_valid && rd_ready && rd_eop: pop the FIFO head and pulse prc_credit_ret in the next cycle. If another entry remains, load it in the same edge (back-to-back, no bubble) and stay in ACTIVE; otherwise rd_valid=0 and go to IDLE.
  - ACTIVE, !rd_ready: all rd_* outputs held stable.
- Latency: a request pushed at edge N with the FIFO empty and FSM in IDLE shows rd_valid high in cycle N+2 (N+1 FIFO write visible, N+2 output register load).
- Segment count = ceil(len/256). rd_bytes on the last segment = ((len-1) mod 256)+1.
- Credits: exactly one prc_credit_ret per accepted or len0-dropped request. A credit is never returned for an overflow-dropped request.
- Simultaneous push and pop on a non-full FIFO: both take effect; count unchanged.

Optional Feature:
- Macro PRC_PFS_RCV_PERF_EN.
- Defined: perf_req_cnt increments per written request; perf_seg_cnt increments per rd_valid&&rd_ready handshake. Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: both ports are present and tied to 0; no counter flops.

Test Plan:
- Single req ptr=0x00100, len=600, port=3, rd_ready=1 -> rd_valid from cycle N+2 for 3 segments: ptr 0x100/0x101/0x102, bytes 256/256/88, sop on first only, eop on last; one prc_credit_ret pulse.
- Requests len=256 then len=1 on consecutive cycles, rd_ready=1 -> two single-segment commands (bytes 256 then 1) with no idle cycle between them; two credit pulses.
- Fill DEPTH=8 with rd_ready=0, then a 9th push -> 9th dropped, err_ovf=1, no extra credit. Release rd_ready -> 8 packets drained, 8 credits.
- rd_ready toggled 1-0-0-1 during len=1000 -> outputs held while stalled; 4 segments, last bytes=232.
- ptr=0xFFFFF, len=512 -> rd_ptr 0xFFFFF then 0x00000. Separately, len=0 -> err_len0=1, no rd_valid, one credit pulse.
- Assert arst during the 2nd segment of a 3-segment packet -> all outputs 0 immediately, FIFO empty, no credit. After release, a new request is processed normally.
